q2s_sweep_ctrl: RTL and testbench

Sequencer that drives the 4-input combinational q2s block through all 16 input vectors {a,b,c,d} = 0..15 in ascending order. It waits a programmable settle time per vector, then samples f and g. Samples are captured into 16-bit response maps and compared against expected truth tables, with a mismatch count and pass flag. It replaces manual vector stepping with an on-chip self-check controller using a start/busy/done handshake.

---
 rtl/q2s_sweep_ctrl_if.sv | 39 +++
 rtl/q2s_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_q2s_sweep_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/q2s_sweep_ctrl_if.sv
// Handshake and vector bus between the q2s sweep sequencer and its environment.
// Q2S_SWEEP_FIRST_FAIL_EN adds the first-failure report signals.
interface q2s_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        a, b, c, d;
  logic        f_in, g_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  vec_idx;
  logic [15:0] f_map;
  logic [15:0] g_map;
  logic [4:0]  mismatch_cnt;
`ifdef Q2S_SWEEP_FIRST_FAIL_EN
  logic [3:0]  first_fail_idx;
  logic        first_fail_vld;

  modport master (
    input  start, abort, f_in, g_in,
    output a, b, c, d, busy, done, pass, vec_idx, f_map, g_map, mismatch_cnt,
           first_fail_idx, first_fail_vld
  );
  modport slave (
    output start, abort, f_in, g_in,
    input  a, b, c, d, busy, done, pass, vec_idx, f_map, g_map, mismatch_cnt,
           first_fail_idx, first_fail_vld
  );
`else
  modport master (
    input  start, abort, f_in, g_in,
    output a, b, c, d, busy, done, pass, vec_idx, f_map, g_map, mismatch_cnt
  );
  modport slave (
    output start, abort, f_in, g_in,
    input  a, b, c, d, busy, done, pass, vec_idx, f_map, g_map, mismatch_cnt
  );
`endif
endinterface

// File: rtl/q2s_sweep_ctrl.sv
// Steps q2s through vectors 0..15, samples f/g after a settle delay and checks them
// against EXP_F/EXP_G. Q2S_SWEEP_FIRST_FAIL_EN adds the first-failing-vector report.
module q2s_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_F         = 16'h0000,
  parameter logic [15:0] EXP_G         = 16'h0000
) (
  input logic              clk,
  input logic              rst,
  q2s_sweep_ctrl_if.master sif
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] WLOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] fmap_q, fmap_d;
  logic [15:0] gmap_q, gmap_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  cnt_nxt;
  logic        mis;
  logic [3:0]  ffi_q, ffi_d;
  logic        ffv_q, ffv_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q  <= '0;
      wcnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fmap_q <= '0;
      gmap_q <= '0;
      cnt_q  <= '0;
      ffi_q  <= '0;
      ffv_q  <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      wcnt_q <= wcnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fmap_q <= fmap_d;
      gmap_q <= gmap_d;
      cnt_q  <= cnt_d;
      ffi_q  <= ffi_d;
      ffv_q  <= ffv_d;
    end
  end

  // Sample-cycle compare; the count saturates at 16 so it can never wrap.
  assign mis     = (sif.f_in != EXP_F[vec_q]) || (sif.g_in != EXP_G[vec_q]);
  assign cnt_nxt = (mis && (cnt_q != 5'd16)) ? cnt_q + 5'd1 : cnt_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fmap_d  = fmap_q;
    gmap_d  = gmap_q;
    cnt_d   = cnt_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    case (state_q)
      S_IDLE: begin
        if (sif.start) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          wcnt_d  = WLOAD;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          cnt_d   = '0;
          fmap_d  = '0;
          gmap_d  = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (sif.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
        end else if (wcnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        // Abort wins over the capture: partial maps stay as they were.
        if (sif.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
        end else begin
          fmap_d[vec_q] = sif.f_in;
          gmap_d[vec_q] = sif.g_in;
          cnt_d         = cnt_nxt;
          if (mis && !ffv_q) begin
            ffi_d = vec_q;
            ffv_d = 1'b1;
          end
          if (vec_q == 4'd15) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (cnt_nxt == 5'd0);
          end else begin
            state_d = S_SETTLE;
            vec_d   = vec_q + 4'd1;
            wcnt_d  = WLOAD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign {sif.a, sif.b, sif.c, sif.d} = vec_q;
  assign sif.vec_idx      = vec_q;
  assign sif.busy         = busy_q;
  assign sif.done         = done_q;
  assign sif.pass         = pass_q;
  assign sif.f_map        = fmap_q;
  assign sif.g_map        = gmap_q;
  assign sif.mismatch_cnt = cnt_q;

`ifdef Q2S_SWEEP_FIRST_FAIL_EN
  assign sif.first_fail_idx = ffi_q;
  assign sif.first_fail_vld = ffv_q;
`else
  logic unused_ff;
  assign unused_ff = ^{ffi_q, ffv_q};
`endif
endmodule

// File: tb/tb_q2s_sweep_ctrl.sv
// Directed bench for q2s_sweep_ctrl: table of full sweeps plus abort/reset/handshake sequences.
module tb_q2s_sweep_ctrl;
  localparam logic [15:0] EF = 16'hA5C3;
  localparam logic [15:0] EG = 16'h0FF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] flip_f = '0;
  logic [15:0] flip_g = '0;

  q2s_sweep_ctrl_if sif0();
  q2s_sweep_ctrl_if sif1();

  q2s_sweep_ctrl #(.SETTLE_CYCLES(2), .EXP_F(EF), .EXP_G(EG)) dut0 (.clk(clk), .rst(rst), .sif(sif0));
  q2s_sweep_ctrl #(.SETTLE_CYCLES(1), .EXP_F(EF), .EXP_G(EG)) dut1 (.clk(clk), .rst(rst), .sif(sif1));

  // q2s stand-in: the expected table, optionally corrupted per vector
  logic [3:0] v0, v1;
  assign v0 = {sif0.a, sif0.b, sif0.c, sif0.d};
  assign v1 = {sif1.a, sif1.b, sif1.c, sif1.d};
  assign sif0.f_in = EF[v0] ^ flip_f[v0];
  assign sif0.g_in = EG[v0] ^ flip_g[v0];
  assign sif1.f_in = EF[v1];
  assign sif1.g_in = EG[v1];

  typedef struct {
    string       name;
    logic [15:0] ff, fg;
    logic [15:0] f_map, g_map;
    logic [4:0]  cnt;
    logic        pass;
    logic [3:0]  ffi;
    logic        ffv;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int all_zero0();
    int e = 0;
    if (sif0.busy !== 1'b0 || sif0.done !== 1'b0 || sif0.pass !== 1'b0) e++;
    if (sif0.vec_idx !== 4'd0 || v0 !== 4'd0) e++;
    if (sif0.f_map !== 16'd0 || sif0.g_map !== 16'd0 || sif0.mismatch_cnt !== 5'd0) e++;
`ifdef Q2S_SWEEP_FIRST_FAIL_EN
    if (sif0.first_fail_idx !== 4'd0 || sif0.first_fail_vld !== 1'b0) e++;
`endif
    return e;
  endfunction

  // Launch a sweep on dut0 and follow it; start is left high when hold is set.
  task automatic sweep0(input bit hold, output int dcyc, output int verr);
    sif0.start = 1'b1;
    tick();
    if (!hold) sif0.start = 1'b0;
    dcyc = 0;
    verr = 0;
    for (int k = 1; k <= 200; k++) begin
      if (sif0.done === 1'b1) begin
        dcyc = k;
        break;
      end
      if (v0 !== 4'((k - 1) / 3) || sif0.vec_idx !== v0 || sif0.busy !== 1'b1) verr++;
      tick();
    end
  endtask

  int dcyc, verr, e;

  initial begin
    tbl[0] = '{"match",  16'h0000, 16'h0000, 16'hA5C3, 16'h0FF0, 5'd0,  1'b1, 4'd0,  1'b0};
    tbl[1] = '{"faulty", 16'h0208, 16'h0200, 16'hA7CB, 16'h0DF0, 5'd2,  1'b0, 4'd3,  1'b1};
    tbl[2] = '{"allbad", 16'hFFFF, 16'h0000, 16'h5A3C, 16'h0FF0, 5'd16, 1'b0, 4'd0,  1'b1};
    tbl[3] = '{"last",   16'h0000, 16'h8000, 16'hA5C3, 16'h8FF0, 5'd1,  1'b0, 4'd15, 1'b1};

    sif0.start = 1'b0; sif0.abort = 1'b0;
    sif1.start = 1'b0; sif1.abort = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_state", all_zero0(), 0);
    rst = 1'b0;
    e = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      e += all_zero0();
    end
    chk("idle_no_start", e, 0);

    for (int t = 0; t < 4; t++) begin
      flip_f = tbl[t].ff;
      flip_g = tbl[t].fg;
      sweep0(1'b0, dcyc, verr);
      chk({tbl[t].name, "_done_cycle"}, dcyc, 49);
      chk({tbl[t].name, "_vec_steps"}, verr, 0);
      chk({tbl[t].name, "_f_map"}, sif0.f_map, tbl[t].f_map);
      chk({tbl[t].name, "_g_map"}, sif0.g_map, tbl[t].g_map);
      chk({tbl[t].name, "_cnt"}, sif0.mismatch_cnt, tbl[t].cnt);
      chk({tbl[t].name, "_pass"}, sif0.pass, tbl[t].pass);
      chk({tbl[t].name, "_busy_in_done"}, sif0.busy, 0);
`ifdef Q2S_SWEEP_FIRST_FAIL_EN
      chk({tbl[t].name, "_ff_idx"}, sif0.first_fail_idx, tbl[t].ffi);
      chk({tbl[t].name, "_ff_vld"}, sif0.first_fail_vld, tbl[t].ffv);
`endif
      tick();
      chk({tbl[t].name, "_done_one_cycle"}, {sif0.done, sif0.vec_idx}, {1'b0, 4'd15});
      chk({tbl[t].name, "_pass_held"}, sif0.pass, tbl[t].pass);
    end

    // abort in the SAMPLE cycle of vector 6 (cycle 21 after accept)
    flip_f = '0;
    flip_g = '0;
    sif0.start = 1'b1;
    tick();
    sif0.start = 1'b0;
    repeat (20) tick();
    chk("abort_at_vec6", sif0.vec_idx, 6);
    sif0.abort = 1'b1;
    tick();
    sif0.abort = 1'b0;
    chk("abort_busy_vec", {sif0.busy, sif0.pass, sif0.vec_idx}, 0);
    chk("abort_f_map", sif0.f_map, 16'h0003);
    chk("abort_g_map", sif0.g_map, 16'h0030);
    chk("abort_cnt", sif0.mismatch_cnt, 0);
    e = 0;
    for (int i = 0; i < 60; i++) begin
      if (sif0.done !== 1'b0 || sif0.busy !== 1'b0) e++;
      tick();
    end
    chk("abort_no_done", e, 0);
    sweep0(1'b0, dcyc, verr);
    chk("restart_done_cycle", dcyc, 49);
    chk("restart_result", {sif0.pass, sif0.f_map, sif0.g_map}, {1'b1, EF, EG});

    // start held high: ignored while busy, re-accepted one cycle after DONE
    repeat (3) tick();
    sweep0(1'b1, dcyc, verr);
    chk("held_done_cycle", dcyc, 49);
    chk("held_vec_steps", verr, 0);
    tick();
    chk("held_idle_gap", {sif0.busy, sif0.done}, 0);
    tick();
    chk("held_reaccept", {sif0.busy, sif0.vec_idx}, {1'b1, 4'd0});
    sif0.start = 1'b0;
    dcyc = 0;
    for (int k = 2; k <= 200; k++) begin
      tick();
      if (sif0.done === 1'b1) begin
        dcyc = k;
        break;
      end
    end
    chk("held_second_done", dcyc, 49);
    tick();

    // synchronous reset in the middle of vector 10
    sif0.start = 1'b1;
    tick();
    sif0.start = 1'b0;
    repeat (30) tick();
    chk("rst_mid_vec10", sif0.vec_idx, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_all_zero", all_zero0(), 0);
    repeat (3) tick();
    chk("rst_mid_stays_idle", all_zero0(), 0);

    // SETTLE_CYCLES=1 instance: two cycles per vector
    sif1.start = 1'b1;
    tick();
    sif1.start = 1'b0;
    dcyc = 0;
    for (int k = 1; k <= 100; k++) begin
      if (sif1.done === 1'b1) begin
        dcyc = k;
        break;
      end
      tick();
    end
    chk("s1_done_cycle", dcyc, 33);
    chk("s1_result", {sif1.pass, sif1.mismatch_cnt, sif1.f_map, sif1.g_map}, {1'b1, 5'd0, EF, EG});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
